// File: rtl/control_unit.sv
// control_unit: fetch/decode sequencer for the ProtoCore 8-bit CPU.
// Optional single-step gating of FETCH: define CTRL_STEP_EN.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  instr_addr,
  input  logic [15:0] instr_data,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  read_a,
  input  logic [7:0]  read_b,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic [2:0]  alu_opcode,
  output logic        write_alu,
  output logic        is_load,
  output logic        imm_flag,
  output logic        write_en,
  output logic [3:0]  write_addr,
  output logic [3:0]  ra_addr,
  output logic [3:0]  rb_addr,
  output logic [7:0]  imm_data,
  output logic        halted
`ifdef CTRL_STEP_EN
  ,
  input  logic        step
`endif
);
  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    LOAD,
    HALT
  } state_t;

  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BC   = 4'hD;
  localparam logic [3:0] OP_ADDI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ld_addr;
  logic [3:0] ir_rd;
  logic       zf;
  logic       cf;

  logic [3:0] op;
  logic [7:0] imm;
  logic [7:0] pc_inc;
  logic       go;
  logic       flag_op;

  assign op      = instr_data[15:12];
  assign imm     = instr_data[7:0];
  assign pc_inc  = pc + 8'd1;
  assign flag_op = !op[3] || (op == OP_ADDI);

`ifdef CTRL_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  assign instr_addr = pc;
  assign halted     = (state == HALT);

  // Sequencer: state, PC, flags and the LD bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= 8'h00;
      ld_addr <= 8'h00;
      ir_rd   <= 4'h0;
      zf      <= 1'b0;
      cf      <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (go) state <= EXEC;
        end
        EXEC: begin
          ir_rd <= instr_data[11:8];
          if (flag_op) begin
            zf <= alu_zero;
            cf <= alu_carry;
          end
          case (op)
            OP_LD: begin
              ld_addr <= read_a;
              state   <= LOAD;
            end
            OP_JMP: begin
              pc    <= imm;
              state <= FETCH;
            end
            OP_BZ: begin
              pc    <= zf ? imm : pc_inc;
              state <= FETCH;
            end
            OP_BC: begin
              pc    <= cf ? imm : pc_inc;
              state <= FETCH;
            end
            OP_HALT: state <= HALT;
            default: begin
              pc    <= pc_inc;
              state <= FETCH;
            end
          endcase
        end
        LOAD: begin
          pc    <= pc_inc;
          state <= FETCH;
        end
        HALT: state <= HALT;
      endcase
    end
  end

  // Datapath/RAM controls: decoded straight from ROM data in EXEC
  always_comb begin
    ram_addr   = 8'h00;
    ram_wdata  = 8'h00;
    ram_we     = 1'b0;
    alu_opcode = 3'b000;
    write_alu  = 1'b0;
    is_load    = 1'b0;
    imm_flag   = 1'b0;
    write_en   = 1'b0;
    write_addr = 4'h0;
    ra_addr    = 4'h0;
    rb_addr    = 4'h0;
    imm_data   = 8'h00;
    unique case (state)
      EXEC: begin
        if (!op[3]) begin
          alu_opcode = op[2:0];
          write_alu  = 1'b1;
          write_en   = 1'b1;
          write_addr = instr_data[11:8];
          ra_addr    = instr_data[7:4];
          rb_addr    = instr_data[3:0];
        end else begin
          case (op)
            OP_LI: begin
              write_en   = 1'b1;
              write_addr = instr_data[11:8];
              imm_data   = imm;
            end
            OP_LD: begin
              ra_addr  = instr_data[7:4];
              ram_addr = read_a;
            end
            OP_ST: begin
              ra_addr   = instr_data[7:4];
              rb_addr   = instr_data[3:0];
              ram_addr  = read_a;
              ram_wdata = read_b;
              ram_we    = 1'b1;
            end
            OP_ADDI: begin
              ra_addr    = instr_data[11:8];
              write_addr = instr_data[11:8];
              imm_flag   = 1'b1;
              write_alu  = 1'b1;
              write_en   = 1'b1;
              imm_data   = imm;
            end
            default: ;
          endcase
        end
      end
      LOAD: begin
        is_load    = 1'b1;
        write_en   = 1'b1;
        write_addr = ir_rd;
        ram_addr   = ld_addr;
      end
      default: ;
    endcase
  end
endmodule
